// File: rtl/board_input_conditioner_if.sv
// Board-input conditioner bus: raw switch/key levels in, debounced levels,
// edge pulses and core reset/clock-enable sequencing out.
interface board_input_conditioner_if #(
  parameter int N_CH = 18
);
  logic [N_CH-1:0] raw_in;
  logic            run_mode;
  logic [N_CH-1:0] db_out;
  logic [N_CH-1:0] rise_pulse;
  logic [N_CH-1:0] fall_pulse;
  logic            core_rst;
  logic            core_ready;
  logic            core_clk_en;

  modport master (
    output raw_in, run_mode,
    input  db_out, rise_pulse, fall_pulse, core_rst, core_ready, core_clk_en
  );

  modport slave (
    input  raw_in, run_mode,
    output db_out, rise_pulse, fall_pulse, core_rst, core_ready, core_clk_en
  );
endinterface

// File: rtl/board_input_conditioner.sv
// Synchronise/debounce N_CH board inputs, emit edge pulses, sequence core reset.
// Optional STEP_MODE_EN: single-step gating of core_clk_en via the step key.
module board_input_conditioner #(
  parameter int              N_CH      = 18,
  parameter int              DB_CYCLES = 250000,
  parameter int              RST_CH    = 0,
  parameter int              STEP_CH   = 1,
  parameter int              RST_HOLD  = 16,
  parameter logic [N_CH-1:0] INIT_VAL  = '0
) (
  input logic                   CLOCK_50,
  input logic                   rst_n,
  board_input_conditioner_if.slave bus
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam int HW = $clog2(RST_HOLD + 1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);

  typedef enum logic [1:0] {
    ST_ASSERT = 2'd0,
    ST_HOLD   = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  logic [N_CH-1:0] sync1_q, sync2_q;
  logic [N_CH-1:0] db_q, db_d;
  logic [N_CH-1:0] rise_q, rise_d;
  logic [N_CH-1:0] fall_q, fall_d;
  logic [CW-1:0]   cnt_q [N_CH];
  logic [CW-1:0]   cnt_d [N_CH];

  state_t          state_q;
  logic [HW-1:0]   hcnt_q;
  logic            core_rst_q, core_ready_q, core_clk_en_q;
  logic            req;
  logic            run_en;

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      db_d[i]   = db_q[i];
      rise_d[i] = 1'b0;
      fall_d[i] = 1'b0;
      cnt_d[i]  = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          db_d[i]   = sync2_q[i];
          rise_d[i] = sync2_q[i];
          fall_d[i] = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= INIT_VAL;
      rise_q  <= '0;
      fall_q  <= '0;
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= bus.raw_in;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign req = db_q[RST_CH];

`ifdef STEP_MODE_EN
  // Step mode: one enable cycle per debounced step-key press, one cycle behind the pulse.
  assign run_en = bus.run_mode | rise_q[STEP_CH];
`else
  logic unused_step;
  assign unused_step = bus.run_mode ^ bus.raw_in[STEP_CH];
  assign run_en      = 1'b1;
`endif

  // The cycle in which ASSERT sees the release counts as the first hold cycle,
  // so core_rst falls exactly RST_HOLD cycles after the debounced release.
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      state_q       <= ST_ASSERT;
      hcnt_q        <= '0;
      core_rst_q    <= 1'b1;
      core_ready_q  <= 1'b0;
      core_clk_en_q <= 1'b0;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          if (!req) begin
            if (RST_HOLD == 1) begin
              state_q       <= ST_RUN;
              core_rst_q    <= 1'b0;
              core_ready_q  <= 1'b1;
              core_clk_en_q <= run_en;
            end else begin
              state_q <= ST_HOLD;
              hcnt_q  <= HW'(1);
            end
          end
        end
        ST_HOLD: begin
          if (req) begin
            state_q <= ST_ASSERT;
          end else if (hcnt_q == HOLD_LAST) begin
            state_q       <= ST_RUN;
            core_rst_q    <= 1'b0;
            core_ready_q  <= 1'b1;
            core_clk_en_q <= run_en;
          end else begin
            hcnt_q <= hcnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (req) begin
            state_q       <= ST_ASSERT;
            core_rst_q    <= 1'b1;
            core_ready_q  <= 1'b0;
            core_clk_en_q <= 1'b0;
          end else begin
            core_clk_en_q <= run_en;
          end
        end
        default: begin
          state_q       <= ST_ASSERT;
          core_rst_q    <= 1'b1;
          core_ready_q  <= 1'b0;
          core_clk_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.db_out      = db_q;
  assign bus.rise_pulse  = rise_q;
  assign bus.fall_pulse  = fall_q;
  assign bus.core_rst    = core_rst_q;
  assign bus.core_ready  = core_ready_q;
  assign bus.core_clk_en = core_clk_en_q;

endmodule

// File: tb/tb_board_input_conditioner.sv
// Directed bench for board_input_conditioner: N_CH=4, DB_CYCLES=4, RST_HOLD=8.
module tb_board_input_conditioner;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  board_input_conditioner_if #(.N_CH(4)) bus ();

  board_input_conditioner #(
    .N_CH(4), .DB_CYCLES(4), .RST_CH(0), .STEP_CH(1), .RST_HOLD(8), .INIT_VAL(4'b0000)
  ) dut (
    .CLOCK_50(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.raw_in = 4'b0000;
    bus.run_mode = 1'b1;
    tick(3);
    checks++; if (bus.db_out !== 4'b0000) begin failures++; $display("FAIL reset_db got=%b exp=0000", bus.db_out); end
    checks++; if (bus.rise_pulse !== 4'b0000) begin failures++; $display("FAIL reset_rise got=%b exp=0000", bus.rise_pulse); end
    checks++; if (bus.fall_pulse !== 4'b0000) begin failures++; $display("FAIL reset_fall got=%b exp=0000", bus.fall_pulse); end
    checks++; if (bus.core_rst !== 1'b1) begin failures++; $display("FAIL reset_core_rst got=%b exp=1", bus.core_rst); end
    checks++; if (bus.core_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", bus.core_ready); end
    checks++; if (bus.core_clk_en !== 1'b0) begin failures++; $display("FAIL reset_clk_en got=%b exp=0", bus.core_clk_en); end
    // db_out[0] is already low, so the release counts from the first active edge
    rst_n = 1'b1;
    tick(7);
    checks++; if (bus.core_rst !== 1'b1) begin failures++; $display("FAIL startup_hold got=%b exp=1", bus.core_rst); end
    tick(1);
    checks++; if (bus.core_rst !== 1'b0) begin failures++; $display("FAIL startup_rst got=%b exp=0", bus.core_rst); end
    checks++; if (bus.core_ready !== 1'b1) begin failures++; $display("FAIL startup_ready got=%b exp=1", bus.core_ready); end
    checks++; if (bus.core_clk_en !== 1'b1) begin failures++; $display("FAIL startup_clk_en got=%b exp=1", bus.core_clk_en); end
  endtask

  task automatic test_edges();
    bus.raw_in[2] = 1'b1;
    tick(5);
    checks++; if (bus.db_out !== 4'b0000) begin failures++; $display("FAIL rise_early_db got=%b exp=0000", bus.db_out); end
    tick(1);
    checks++; if (bus.db_out !== 4'b0100) begin failures++; $display("FAIL rise_db got=%b exp=0100", bus.db_out); end
    checks++; if (bus.rise_pulse !== 4'b0100) begin failures++; $display("FAIL rise_pulse got=%b exp=0100", bus.rise_pulse); end
    checks++; if (bus.fall_pulse !== 4'b0000) begin failures++; $display("FAIL rise_no_fall got=%b exp=0000", bus.fall_pulse); end
    tick(1);
    checks++; if (bus.rise_pulse !== 4'b0000) begin failures++; $display("FAIL rise_one_cycle got=%b exp=0000", bus.rise_pulse); end
    checks++; if (bus.db_out !== 4'b0100) begin failures++; $display("FAIL rise_held_db got=%b exp=0100", bus.db_out); end
    bus.raw_in[2] = 1'b0;
    tick(5);
    checks++; if (bus.db_out !== 4'b0100) begin failures++; $display("FAIL fall_early_db got=%b exp=0100", bus.db_out); end
    tick(1);
    checks++; if (bus.db_out !== 4'b0000) begin failures++; $display("FAIL fall_db got=%b exp=0000", bus.db_out); end
    checks++; if (bus.fall_pulse !== 4'b0100) begin failures++; $display("FAIL fall_pulse got=%b exp=0100", bus.fall_pulse); end
    checks++; if (bus.rise_pulse !== 4'b0000) begin failures++; $display("FAIL fall_no_rise got=%b exp=0000", bus.rise_pulse); end
    tick(1);
    checks++; if (bus.fall_pulse !== 4'b0000) begin failures++; $display("FAIL fall_one_cycle got=%b exp=0000", bus.fall_pulse); end
  endtask

  task automatic test_glitch();
    bus.raw_in[3] = 1'b1;
    tick(3);
    bus.raw_in[3] = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick(1);
      checks++;
      if (bus.db_out !== 4'b0000 || bus.rise_pulse !== 4'b0000 || bus.fall_pulse !== 4'b0000) begin
        failures++;
        $display("FAIL glitch_c%0d db=%b rise=%b fall=%b exp all 0000", c, bus.db_out, bus.rise_pulse, bus.fall_pulse);
      end
    end
    checks++; if (bus.core_ready !== 1'b1) begin failures++; $display("FAIL glitch_ready got=%b exp=1", bus.core_ready); end
  endtask

  task automatic test_run_reset();
    bus.raw_in[0] = 1'b1;
    tick(6);
    checks++; if (bus.db_out[0] !== 1'b1) begin failures++; $display("FAIL req_db got=%b exp=1", bus.db_out[0]); end
    checks++; if (bus.core_rst !== 1'b0) begin failures++; $display("FAIL req_rst_lag got=%b exp=0", bus.core_rst); end
    tick(1);
    checks++; if (bus.core_rst !== 1'b1) begin failures++; $display("FAIL req_rst got=%b exp=1", bus.core_rst); end
    checks++; if (bus.core_ready !== 1'b0) begin failures++; $display("FAIL req_ready got=%b exp=0", bus.core_ready); end
    checks++; if (bus.core_clk_en !== 1'b0) begin failures++; $display("FAIL req_clk_en got=%b exp=0", bus.core_clk_en); end
    tick(3);
    bus.raw_in[0] = 1'b0;
    tick(6);
    checks++; if (bus.db_out[0] !== 1'b0) begin failures++; $display("FAIL rel_db got=%b exp=0", bus.db_out[0]); end
    for (int k = 1; k < 8; k++) begin
      tick(1);
      checks++; if (bus.core_rst !== 1'b1) begin failures++; $display("FAIL rel_hold_%0d got=%b exp=1", k, bus.core_rst); end
    end
    tick(1);
    checks++; if (bus.core_rst !== 1'b0) begin failures++; $display("FAIL rel_rst got=%b exp=0", bus.core_rst); end
    checks++; if (bus.core_ready !== 1'b1) begin failures++; $display("FAIL rel_ready got=%b exp=1", bus.core_ready); end
    checks++; if (bus.core_clk_en !== 1'b1) begin failures++; $display("FAIL rel_clk_en got=%b exp=1", bus.core_clk_en); end
  endtask

  task automatic test_hold_abort();
    bus.raw_in[0] = 1'b1;
    tick(10);
    bus.raw_in[0] = 1'b0;
    tick(4);
    bus.raw_in[0] = 1'b1;
    // cycle 14 now: db[0] falls at 16, rises again at 20 (HOLD cycle 4)
    for (int c = 15; c <= 30; c++) begin
      tick(1);
      checks++;
      if (bus.core_rst !== 1'b1 || bus.core_ready !== 1'b0) begin
        failures++;
        $display("FAIL abort_c%0d rst=%b ready=%b exp rst=1 ready=0", c, bus.core_rst, bus.core_ready);
      end
      if (c == 16) begin
        checks++; if (bus.db_out[0] !== 1'b0) begin failures++; $display("FAIL abort_db_low got=%b exp=0", bus.db_out[0]); end
      end
      if (c == 20) begin
        checks++; if (bus.db_out[0] !== 1'b1) begin failures++; $display("FAIL abort_db_high got=%b exp=1", bus.db_out[0]); end
      end
    end
    bus.raw_in[0] = 1'b0;
    tick(13);
    checks++; if (bus.core_rst !== 1'b1) begin failures++; $display("FAIL restart_hold got=%b exp=1", bus.core_rst); end
    tick(1);
    checks++; if (bus.core_rst !== 1'b0) begin failures++; $display("FAIL restart_rst got=%b exp=0", bus.core_rst); end
    checks++; if (bus.core_ready !== 1'b1) begin failures++; $display("FAIL restart_ready got=%b exp=1", bus.core_ready); end
  endtask

`ifdef STEP_MODE_EN
  task automatic test_step();
    int en_count;
    en_count = 0;
    bus.run_mode = 1'b0;
    tick(1);
    checks++; if (bus.core_clk_en !== 1'b0) begin failures++; $display("FAIL step_mode_off got=%b exp=0", bus.core_clk_en); end
    for (int p = 0; p < 3; p++) begin
      bus.raw_in[1] = 1'b1;
      for (int c = 1; c <= 16; c++) begin
        tick(1);
        if (c == 8) bus.raw_in[1] = 1'b0;
        if (bus.core_clk_en === 1'b1) en_count++;
        checks++;
        if (bus.core_clk_en !== (c == 7)) begin
          failures++;
          $display("FAIL step_p%0d_c%0d got=%b exp=%b", p, c, bus.core_clk_en, (c == 7));
        end
      end
    end
    checks++; if (en_count != 3) begin failures++; $display("FAIL step_count got=%0d exp=3", en_count); end
    bus.run_mode = 1'b1;
    tick(1);
    checks++; if (bus.core_clk_en !== 1'b1) begin failures++; $display("FAIL step_free_run got=%b exp=1", bus.core_clk_en); end
  endtask
`else
  task automatic test_run_mode_ignored();
    bus.run_mode = 1'b0;
    bus.raw_in[1] = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      tick(1);
      if (c == 8) bus.raw_in[1] = 1'b0;
      checks++;
      if (bus.core_clk_en !== 1'b1) begin failures++; $display("FAIL ignore_c%0d got=%b exp=1", c, bus.core_clk_en); end
      if (c == 6) begin
        checks++; if (bus.rise_pulse !== 4'b0010) begin failures++; $display("FAIL ignore_rise got=%b exp=0010", bus.rise_pulse); end
      end
    end
    bus.run_mode = 1'b1;
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_edges();
    test_glitch();
    test_run_reset();
    test_hold_abort();
`ifdef STEP_MODE_EN
    test_step();
`else
    test_run_mode_ignored();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
